// File: rtl/fan_ctrl_mc.sv
// fan_ctrl_mc: multi-channel PI fan controller with time-multiplexed datapath, shared PWM counter and kick-start
module fan_ctrl_mc #(
  parameter int CHANNELS      = 4,
  parameter int ADC_BITWIDTH  = 8,
  parameter int COEF_BITWIDTH = 12,
  parameter int FRAC_BITWIDTH = 8,
  parameter int UPDATE_DIV    = 5000,
  parameter int KICK_PERIODS  = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 clk_en_i,
  input  logic [CHANNELS*ADC_BITWIDTH-1:0]     ADC_value_i,
  input  logic [CHANNELS*ADC_BITWIDTH-1:0]     SET_value_i,
  input  logic signed [COEF_BITWIDTH-1:0]      kp_i,
  input  logic signed [COEF_BITWIDTH-1:0]      ki_i,
  input  logic [CHANNELS-1:0]                  ch_enable_i,
  input  logic [ADC_BITWIDTH:0]                PWM_periodCounterValue_i,
  input  logic [ADC_BITWIDTH-1:0]              PWM_minCounterValue_i,
  output logic [CHANNELS-1:0]                  PWM_pin_o,
  output logic [CHANNELS*ADC_BITWIDTH-1:0]     duty_o,
  output logic                                 sweep_done_o
);
  localparam int W  = ADC_BITWIDTH;
  localparam int F  = FRAC_BITWIDTH;
  localparam int IW = W + F;
  localparam int AW = W + F + COEF_BITWIDTH + 3;
  localparam int UW = $clog2(UPDATE_DIV);
  localparam int CW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int KW = KICK_PERIODS > 0 ? $clog2(KICK_PERIODS + 1) : 1;
  localparam logic [UW-1:0] UPD_LAST = UW'(UPDATE_DIV - 1);
  localparam logic [CW-1:0] CH_LAST = CW'(CHANNELS - 1);
  localparam logic [KW-1:0] KICK_LD = KW'(KICK_PERIODS);
  localparam logic signed [AW-1:0] IMAX = AW'({{W{1'b1}}, {F{1'b0}}});
  localparam logic signed [AW-1:0] DMAX = AW'({W{1'b1}});

  typedef enum logic [1:0] {IDLE, LOAD, CALC, WRITE} state_t;

  state_t                        st_q;
  logic [UW-1:0]                 upd_q;
  logic [CW-1:0]                 ch_q;
  logic signed [W:0]             err_q;
  logic                          en_q;
  logic                          done_q;
  logic [CHANNELS-1:0][IW-1:0]   integ_q;
  logic [CHANNELS-1:0][W-1:0]    duty_q;
  logic [CHANNELS-1:0][W-1:0]    shd_q;
  logic [CHANNELS-1:0][KW-1:0]   kick_q;
  logic [W:0]                    pcnt_q;
  logic [W:0]                    pcnt_d;
  logic [IW-1:0]                 integ_d;
  logic [W-1:0]                  duty_d;
  logic signed [AW-1:0]          err_x;
  logic signed [AW-1:0]          integ_x;
  logic signed [AW-1:0]          isum;
  logic signed [AW-1:0]          dsh;
  logic                          p_ok;
  logic                          wrap;

  // WRITE reads integ_q after CALC has stored the new integrator value
  always_comb begin
    err_x   = AW'(err_q);
    integ_x = AW'($signed({1'b0, integ_q[ch_q]}));
    isum    = integ_x + err_x * AW'(ki_i);
    dsh     = (err_x * AW'(kp_i) + integ_x) >>> F;
    integ_d = isum[AW-1] ? '0 : isum > IMAX ? IMAX[IW-1:0] : isum[IW-1:0];
    duty_d  = dsh[AW-1] ? '0 : dsh > DMAX ? '1 : dsh[W-1:0];
  end

  assign p_ok   = |PWM_periodCounterValue_i[W:1];
  assign pcnt_d = (!p_ok || pcnt_q >= PWM_periodCounterValue_i - 1'b1) ? '0 : pcnt_q + 1'b1;
  assign wrap   = pcnt_d == '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q    <= IDLE;
      upd_q   <= '0;
      ch_q    <= '0;
      err_q   <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      integ_q <= '0;
      duty_q  <= '0;
      shd_q   <= '0;
      kick_q  <= '0;
      pcnt_q  <= '0;
    end else if (clk_en_i) begin
      upd_q  <= upd_q == UPD_LAST ? '0 : upd_q + 1'b1;
      pcnt_q <= pcnt_d;
      done_q <= 1'b0;
      case (st_q)
        IDLE: if (upd_q == UPD_LAST) begin
          ch_q <= '0;
          st_q <= LOAD;
        end
        LOAD: begin
          err_q <= {1'b0, ADC_value_i[ch_q*W +: W]} - {1'b0, SET_value_i[ch_q*W +: W]};
          en_q  <= ch_enable_i[ch_q];
          st_q  <= CALC;
        end
        CALC: begin
          integ_q[ch_q] <= en_q ? integ_d : '0;
          st_q          <= WRITE;
        end
        WRITE: begin
          duty_q[ch_q] <= en_q ? duty_d : '0;
          done_q       <= ch_q == CH_LAST;
          st_q         <= ch_q == CH_LAST ? IDLE : LOAD;
          ch_q         <= ch_q + 1'b1;
        end
      endcase
      // shadows and kick counters advance only as the PWM counter enters 0
      if (wrap) for (int c = 0; c < CHANNELS; c++) begin
        shd_q[c]  <= duty_q[c];
        kick_q[c] <= duty_q[c] == '0 ? '0 : shd_q[c] == '0 ? KICK_LD :
                     kick_q[c] != '0 ? kick_q[c] - 1'b1 : '0;
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pwm
    logic [W-1:0] eff;
    assign eff = shd_q[g] == '0 ? '0 :
                 shd_q[g] < PWM_minCounterValue_i ? PWM_minCounterValue_i : shd_q[g];
    assign PWM_pin_o[g] = p_ok && (kick_q[g] != '0 || pcnt_q < {1'b0, eff});
  end

  assign duty_o       = duty_q;
  assign sweep_done_o = done_q;
endmodule
